// File: rtl/conv2_feeder_if.sv
// conv2 input bus: one-cycle beat strobe plus payload,
// and the per-channel weights/bias held alongside it.
interface conv2_feeder_if;
  logic         valid_o;
  logic [319:0] data_o;
  logic [71:0]  weight_o;
  logic [15:0]  bias_o;

  modport master (
    output valid_o,
    output data_o,
    output weight_o,
    output bias_o
  );

  modport slave (
    input valid_o,
    input data_o,
    input weight_o,
    input bias_o
  );
endinterface

// File: rtl/conv2_feeder.sv
// conv2 feeder: reads activation rows and channel parameters
// from SRAM and emits A/B beats per channel on the conv2 bus.
module conv2_feeder #(
  parameter int NUM_CH    = 32,
  parameter int ADDR_W    = 10,
  parameter int PADDR_W   = 6,
  parameter int GAP_AB    = 9,
  parameter int GAP_BA    = 9,
  parameter int CLAMP_NEG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               act_re,
  output logic [ADDR_W-1:0]  act_addr,
  input  logic [79:0]        act_rdata,
  output logic               par_re,
  output logic [PADDR_W-1:0] par_addr,
  input  logic [87:0]        par_rdata,
  conv2_feeder_if.master     bus
);

  localparam int GMAX =
    (GAP_AB > GAP_BA) ? GAP_AB : GAP_BA;
  localparam int GW = $clog2(GMAX + 2);
  localparam int CW =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [GW-1:0] G_SAT = GW'(GMAX);
  localparam logic [GW-1:0] AB_M1 =
    GW'((GAP_AB > 0) ? GAP_AB - 1 : 0);
  localparam logic [GW-1:0] BA_M1 =
    GW'((GAP_BA > 0) ? GAP_BA - 1 : 0);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  typedef enum logic [3:0] {
    IDLE, RD_A, WAIT_A, FIRE_A, RD_P,
    RD_B, WAIT_B, FIRE_B, HOLD, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [2:0]     rd_cnt_q, rd_cnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           cap_v_q, cap_v_d;
  logic [1:0]     cap_row_q, cap_row_d;
  logic           par_v_q, par_v_d;
  logic [319:0]   stage_q, stage_d;
  logic [319:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic [71:0]    weight_q, weight_d;
  logic [15:0]    bias_q, bias_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           rd_st;
  logic           beat_b;

  function automatic logic [79:0] clamp_row(
    input logic [79:0] r
  );
    logic [79:0] o;
    for (int j = 0; j < 10; j++) begin
      if (CLAMP_NEG != 0 && r[j*8+7])
        o[j*8 +: 8] = 8'h00;
      else
        o[j*8 +: 8] = r[j*8 +: 8];
    end
    return o;
  endfunction

  always_comb begin
    rd_st    = (state_q == RD_A) ||
               (state_q == RD_B);
    beat_b   = (state_q == RD_B);
    act_re   = rd_st && !rd_cnt_q[2];
    act_addr = '0;
    if (act_re)
      act_addr = ADDR_W'({ch_q, beat_b,
                          rd_cnt_q[1:0]});
    par_re   = (state_q == RD_P);
    par_addr = '0;
    if (par_re)
      par_addr = PADDR_W'(ch_q);
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rd_cnt_d  = rd_cnt_q;
    gap_d     = (gap_q == G_SAT) ? gap_q
                : gap_q + GW'(1);
    cap_v_d   = act_re;
    cap_row_d = rd_cnt_q[1:0];
    par_v_d   = par_re;
    stage_d   = stage_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    weight_d  = weight_q;
    bias_d    = bias_q;
    done_d    = 1'b0;
    // SRAM data arrives one cycle after its read enable
    if (cap_v_q)
      stage_d[cap_row_q*80 +: 80] =
        clamp_row(act_rdata);
    if (par_v_q) begin
      weight_d = par_rdata[71:0];
      bias_d   = par_rdata[87:72];
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RD_A;
          ch_d     = '0;
          rd_cnt_d = '0;
          gap_d    = G_SAT;
        end
      end
      RD_A, RD_B: begin
        rd_cnt_d = rd_cnt_q + 3'd1;
        if (rd_cnt_q == 3'd4) begin
          rd_cnt_d = '0;
          state_d  = (state_q == RD_A) ?
                     WAIT_A : WAIT_B;
        end
      end
      WAIT_A: if (gap_q >= BA_M1) state_d = FIRE_A;
      WAIT_B: if (gap_q >= AB_M1) state_d = FIRE_B;
      FIRE_A, FIRE_B: begin
        data_d  = stage_q;
        valid_d = 1'b1;
        gap_d   = GW'(1);
        state_d = (state_q == FIRE_A) ?
                  RD_P : HOLD;
      end
      RD_P: state_d = RD_B;
      HOLD: begin
        // next channel's reads overlap the B->A gap
        if (ch_q == LAST) begin
          if (gap_q >= BA_M1) state_d = DONE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = RD_A;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      rd_cnt_q  <= '0;
      gap_q     <= '0;
      cap_v_q   <= 1'b0;
      cap_row_q <= '0;
      par_v_q   <= 1'b0;
      stage_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      weight_q  <= '0;
      bias_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rd_cnt_q  <= rd_cnt_d;
      gap_q     <= gap_d;
      cap_v_q   <= cap_v_d;
      cap_row_q <= cap_row_d;
      par_v_q   <= par_v_d;
      stage_q   <= stage_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      weight_q  <= weight_d;
      bias_q    <= bias_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;
  assign bus.weight_o = weight_q;
  assign bus.bias_o   = bias_q;

endmodule

// File: tb/tb_conv2_feeder.sv
// Bench for conv2_feeder: a 32-channel clamping instance and
// a 1-channel pass-through instance against an SRAM model.
module tb_conv2_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        start32 = 1'b0, start1 = 1'b0;
  logic        busy32, done32, busy1, done1;
  logic        are32, pre32, are1, pre1;
  logic [9:0]  aaddr32, aaddr1;
  logic [5:0]  paddr32, paddr1;
  logic [79:0] ard32, ard1;
  logic [87:0] prd32, prd1;

  logic [79:0] am32 [0:1023];
  logic [87:0] pm32 [0:63];
  logic [79:0] am1  [0:1023];
  logic [87:0] pm1  [0:63];

  conv2_feeder_if b32 ();
  conv2_feeder_if b1 ();

  conv2_feeder #(.NUM_CH(32), .CLAMP_NEG(1)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .busy(busy32), .done(done32),
    .act_re(are32), .act_addr(aaddr32),
    .act_rdata(ard32),
    .par_re(pre32), .par_addr(paddr32),
    .par_rdata(prd32), .bus(b32)
  );

  conv2_feeder #(.NUM_CH(1), .CLAMP_NEG(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1),
    .act_re(are1), .act_addr(aaddr1),
    .act_rdata(ard1),
    .par_re(pre1), .par_addr(paddr1),
    .par_rdata(prd1), .bus(b1)
  );

  always @(posedge clk) begin
    if (are32) ard32 <= am32[aaddr32];
    if (pre32) prd32 <= pm32[paddr32];
    if (are1)  ard1  <= am1[aaddr1];
    if (pre1)  prd1  <= pm1[paddr1];
  end

  int nv32 = 0, nd32 = 0, dbl = 0;
  int coin = 0, ovl = 0, abad = 0;
  logic pv32 = 1'b0;
  logic [9:0] aq [$];

  always @(negedge clk) begin
    pv32 <= b32.valid_o;
    if (b32.valid_o) nv32 <= nv32 + 1;
    if (done32) nd32 <= nd32 + 1;
    if (b32.valid_o && pv32) dbl <= dbl + 1;
    if ((b32.valid_o && done32) ||
        (b1.valid_o && done1))
      coin <= coin + 1;
    if ((are32 && pre32) || (are1 && pre1))
      ovl <= ovl + 1;
    if ((!are32 && aaddr32 != 0) ||
        (!pre32 && paddr32 != 0) ||
        (!are1 && aaddr1 != 0) ||
        (!pre1 && paddr1 != 0))
      abad <= abad + 1;
    if (are32) aq.push_back(aaddr32);
  end

  task automatic chk(input string tag,
                     input logic [319:0] obs,
                     input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ev(input bit d1,
                         input bit is_done,
                         output int c);
    logic hit;
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done) hit = d1 ? done1 : done32;
      else hit = d1 ? b1.valid_o : b32.valid_o;
      if (hit === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk(is_done ? "done_seen" : "valid_seen",
        {31'd0, c >= 0}, 1);
  endtask

  task automatic pulse(input bit d1);
    @(negedge clk);
    if (d1) start1 = 1'b1;
    else start32 = 1'b1;
    @(negedge clk);
    start1  = 1'b0;
    start32 = 1'b0;
  endtask

  function automatic logic [319:0] exp_beat(
    input bit d1, input int ch, input int beat);
    logic [79:0]  row;
    logic [7:0]   b;
    logic [319:0] e;
    e = '0;
    for (int r = 0; r < 4; r++) begin
      if (d1) row = am1[ch*8 + beat*4 + r];
      else row = am32[ch*8 + beat*4 + r];
      for (int j = 0; j < 10; j++) begin
        b = row[j*8 +: 8];
        if (!d1 && b > 8'd127) b = 8'd0;
        e[(r*10 + j)*8 +: 8] = b;
      end
    end
    return e;
  endfunction

  logic [87:0] prev_p;
  int last_b;

  task automatic check_ch32(input int c,
                            input bit poke);
    int ca, cb;
    wait_ev(1'b0, 1'b0, ca);
    if (c > 0) chk("gap_ba", ca - last_b, 9);
    chk($sformatf("ch%0d_a", c),
        b32.data_o, exp_beat(1'b0, c, 0));
    chk("busy_run", {319'd0, busy32}, 1);
    if (poke && c == 5) start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("w_hold", {b32.bias_o, b32.weight_o},
        prev_p);
    @(negedge clk);
    chk($sformatf("ch%0d_w", c),
        {b32.bias_o, b32.weight_o}, pm32[c]);
    prev_p = pm32[c];
    wait_ev(1'b0, 1'b0, cb);
    chk("gap_ab", cb - ca, 9);
    chk($sformatf("ch%0d_b", c),
        b32.data_o, exp_beat(1'b0, c, 1));
    last_b = cb;
  endtask

  initial begin
    int ca, cb, cd;
    int s_nv, s_nd, s_dbl, qb, aerr;

    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < 10; j++) begin
        am32[a][j*8 +: 8] = 8'($urandom);
        am1[a][j*8 +: 8]  = 8'((a % 8) + 1);
      end
    for (int j = 0; j < 10; j++)
      am32[0][j*8 +: 8] = (j % 3 == 0) ? 8'h80 :
                          (j % 3 == 1) ? 8'hFF : 8'h7F;
    for (int p = 0; p < 64; p++)
      for (int k = 0; k < 11; k++)
        pm32[p][k*8 +: 8] = 8'($urandom);
    pm1[0] = {16'd300, {9{8'd2}}};

    repeat (3) @(negedge clk);
    chk("rst_valid", {319'd0, b32.valid_o}, 0);
    chk("rst_data", b32.data_o, 0);
    chk("rst_wb", {b32.bias_o, b32.weight_o}, 0);
    chk("rst_ctl", {busy32, done32, are32, pre32,
                    busy1, done1, are1, pre1}, 0);
    chk("rst_out1", {b1.valid_o, b1.bias_o,
                     b1.weight_o}, 0);
    rst = 1'b0;

    pulse(1'b1);
    wait_ev(1'b1, 1'b0, ca);
    chk("n1_a", b1.data_o, exp_beat(1'b1, 0, 0));
    chk("n1_a_b0", b1.data_o[7:0], 1);
    chk("n1_a_b39", b1.data_o[319:312], 4);
    @(negedge clk);
    chk("n1_w_old", {b1.bias_o, b1.weight_o}, 0);
    @(negedge clk);
    chk("n1_w", b1.weight_o, {9{8'd2}});
    chk("n1_bias", b1.bias_o, 300);
    wait_ev(1'b1, 1'b0, cb);
    chk("n1_gap_ab", cb - ca, 9);
    chk("n1_b", b1.data_o, exp_beat(1'b1, 0, 1));
    chk("n1_b_b0", b1.data_o[7:0], 5);
    wait_ev(1'b1, 1'b1, cd);
    chk("n1_done_gap", cd - cb, 9);
    @(negedge clk);
    chk("n1_idle", {319'd0, busy1}, 0);

    for (int a = 0; a < 8; a++)
      for (int j = 0; j < 10; j++)
        am1[a][j*8 +: 8] = (j % 3 == 0) ? 8'h80 :
                           (j % 3 == 1) ? 8'hFF : 8'h7F;
    for (int k = 0; k < 11; k++)
      pm1[0][k*8 +: 8] = 8'($urandom);
    pulse(1'b1);
    wait_ev(1'b1, 1'b0, ca);
    chk("nc_a", b1.data_o, exp_beat(1'b1, 0, 0));
    chk("nc_bytes", b1.data_o[23:0], 24'h7FFF80);
    @(negedge clk);
    chk("nc_w_old", {b1.bias_o, b1.weight_o},
        {16'd300, {9{8'd2}}});
    @(negedge clk);
    chk("nc_w", {b1.bias_o, b1.weight_o}, pm1[0]);
    wait_ev(1'b1, 1'b0, cb);
    chk("nc_b", b1.data_o, exp_beat(1'b1, 0, 1));
    wait_ev(1'b1, 1'b1, cd);

    s_nv = nv32; s_nd = nd32; s_dbl = dbl;
    qb = aq.size();
    prev_p = '0;
    last_b = 0;
    pulse(1'b0);
    for (int c = 0; c < 32; c++) check_ch32(c, 1'b1);
    chk("c0_clamp", b32.data_o[7:0] | 8'h00,
        b32.data_o[7:0]);
    wait_ev(1'b0, 1'b1, cd);
    chk("done_gap", cd - last_b, 9);
    repeat (3) @(negedge clk);
    chk("pulses", nv32 - s_nv, 64);
    chk("wide", dbl - s_dbl, 0);
    chk("dones", nd32 - s_nd, 1);
    chk("coincide", coin, 0);
    chk("re_overlap", ovl, 0);
    chk("addr_idle0", abad, 0);
    chk("n_reads", aq.size() - qb, 256);
    aerr = 0;
    for (int i = 0; i < 256; i++)
      if (qb + i < aq.size())
        if (aq[qb + i] != 10'(i)) aerr++;
    chk("addr_seq", aerr, 0);
    chk("idle_end", {319'd0, busy32}, 0);

    qb = aq.size();
    pulse(1'b0);
    for (int c = 0; c < 3; c++) check_ch32(c, 1'b0);
    wait_ev(1'b0, 1'b0, ca);
    repeat (6) @(negedge clk);
    s_nd = nd32;
    rst = 1'b1;
    start32 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start32 = 1'b0;
    chk("mr_valid", {319'd0, b32.valid_o}, 0);
    chk("mr_data", b32.data_o, 0);
    chk("mr_wb", {b32.bias_o, b32.weight_o}, 0);
    chk("mr_ctl", {busy32, done32, are32,
                   pre32, aaddr32, paddr32}, 0);
    s_nv = nv32;
    @(negedge clk);
    chk("rst_beats_start", {319'd0, busy32}, 0);
    repeat (40) @(negedge clk);
    chk("mr_no_done", nd32 - s_nd, 0);
    chk("mr_no_valid", nv32 - s_nv, 0);

    qb = aq.size();
    prev_p = '0;
    pulse(1'b0);
    check_ch32(0, 1'b0);
    chk("restart_addr",
        (aq.size() > qb) ? aq[qb] : 10'h3FF, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
